fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC pipeline. It holds the program counter (PC) and reads a 32-bit instruction combinationally from a private byte-addressed instruction memory. It provides PC+4 to the rest of the pipeline and selects the next PC from start address, branch target or sequential increment. The decode stage consumes its outputs; the branch target and select come from the execute/branch logic.

---
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and a combinational
// little-endian read from a private byte-addressed instruction memory.

module fetch_unit_imem #(
    parameter int MEM_BYTES = 1024
) (
    input  logic [$clog2(MEM_BYTES)-1:0] addr,
    output logic [31:0]                  data
);
    localparam int AW = $clog2(MEM_BYTES);

    // Contents are placed here by the surrounding environment; nothing in the
    // datapath ever writes or resets this array.
    logic [7:0] Data_Memory [0:MEM_BYTES-1];

    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [AW-1:0] addr3;

    // AW-bit adds wrap the byte index around the end of the memory.
    assign addr1 = addr + AW'(1);
    assign addr2 = addr + AW'(2);
    assign addr3 = addr + AW'(3);

    assign data = {Data_Memory[addr3], Data_Memory[addr2],
                   Data_Memory[addr1], Data_Memory[addr]};
endmodule

module fetch_unit #(
    parameter int                word_size  = 32,
    parameter int                MEM_BYTES  = 1024,
    parameter logic [word_size-1:0] RESET_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [word_size-1:0] instruction,
    output logic [word_size-1:0] PC_next_normal,
    input  logic [word_size-1:0] PC_next_branch,
    input  logic                 PCSrc,
    input  logic                 start
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [word_size-1:0] PC;
    logic [word_size-1:0] start_address;

    assign PC_next_normal = PC + word_size'(4);

    // start wins over PCSrc so a restart is never disturbed by a stale branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            PC            <= RESET_ADDR;
            start_address <= RESET_ADDR;
        end else if (start) begin
            PC <= start_address;
        end else if (PCSrc) begin
            PC <= PC_next_branch;
        end else begin
            PC <= PC_next_normal;
        end
    end

    fetch_unit_imem #(
        .MEM_BYTES(MEM_BYTES)
    ) instruction_memory (
        .addr(PC[AW-1:0]),
        .data(instruction)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table plus hand-written corner
// sequences, all checked through an expected-value queue.

module tb_fetch_unit;
    localparam int MEM = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] PC_next_normal;
    logic [31:0] PC_next_branch;
    logic        PCSrc;
    logic        start;

    fetch_unit #(
        .word_size (32),
        .MEM_BYTES (MEM),
        .RESET_ADDR(32'h0)
    ) F0 (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .PC_next_normal(PC_next_normal),
        .PC_next_branch(PC_next_branch),
        .PCSrc         (PCSrc),
        .start         (start)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference memory / scoreboard ----------------
    logic [7:0]  tb_mem [0:MEM-1];
    logic [95:0] exp_q[$];   // {pc, pc+4, instruction}
    int          n_vec;
    int          n_fail;

    typedef struct {
        bit          r;
        bit          s;
        bit          p;
        logic [31:0] br;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [31:0] model_instr(input logic [31:0] pc);
        int a;
        a = int'(pc[9:0]);
        return {tb_mem[(a + 3) % MEM], tb_mem[(a + 2) % MEM],
                tb_mem[(a + 1) % MEM], tb_mem[a]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_out(input string nm);
        logic [95:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: got empty queue expected an entry", nm);
        end else begin
            e = exp_q.pop_front();
            check({nm, ".pc"},    F0.PC,          e[95:64]);
            check({nm, ".next"},  PC_next_normal, e[63:32]);
            check({nm, ".instr"}, instruction,    e[31:0]);
        end
    endtask

    // Drive one cycle's inputs, queue the expected result, compare after the edge.
    task automatic step(input bit r, input bit s, input bit p, input logic [31:0] br,
                        input logic [31:0] exp_pc, input string nm);
        rst            = r;
        start          = s;
        PCSrc          = p;
        PC_next_branch = br;
        exp_q.push_back({exp_pc, exp_pc + 32'd4, model_instr(exp_pc)});
        @(posedge clk);
        @(negedge clk);
        compare_out(nm);
    endtask

    task automatic load_mem();
        for (int i = 0; i < MEM; i++) F0.instruction_memory.Data_Memory[i] = tb_mem[i];
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_sa;
        logic [31:0] br;
        bit          r;
        bit          s;
        bit          p;
        logic [7:0]  init_bytes [0:11];

        n_vec          = 0;
        n_fail         = 0;
        rst            = 1'b0;
        start          = 1'b0;
        PCSrc          = 1'b0;
        PC_next_branch = '0;

        init_bytes = '{8'h02, 8'h04, 8'h05, 8'h06, 8'h01, 8'h08,
                       8'h09, 8'h10, 8'h13, 8'h32, 8'h56, 8'h69};
        for (int i = 0; i < MEM; i++) tb_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 12; i++) tb_mem[i] = init_bytes[i];
        load_mem();

        // Reset, start, sequential fetch, branch, wrap and misaligned cases.
        vecs[0]  = '{0, 0, 0, 32'h0,        32'h0};
        vecs[1]  = '{1, 1, 1, 32'h0000_0300, 32'h0};
        vecs[2]  = '{1, 0, 0, 32'h0,        32'h4};
        vecs[3]  = '{1, 0, 0, 32'h0,        32'h8};
        vecs[4]  = '{1, 0, 1, 32'h420,      32'h420};
        vecs[5]  = '{1, 0, 0, 32'h0,        32'h424};
        vecs[6]  = '{1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[7]  = '{1, 0, 0, 32'h0,        32'h0};
        vecs[8]  = '{1, 0, 1, 32'h3FE,      32'h3FE};
        vecs[9]  = '{1, 0, 1, 32'h101,      32'h101};
        vecs[10] = '{1, 0, 0, 32'h0,        32'h105};
        vecs[11] = '{1, 0, 0, 32'h0,        32'h109};
        vecs[12] = '{0, 1, 1, 32'h200,      32'h0};

        for (int i = 0; i < 13; i++) begin
            // PCSrc is a don't-care under start; give it a random value.
            p = (vecs[i].s) ? 1'($urandom_range(0, 1)) : vecs[i].p;
            if (i == 1) F0.start_address <= 32'h0;
            step(vecs[i].r, vecs[i].s, p, vecs[i].br, vecs[i].exp_pc, $sformatf("vec%0d", i));
        end
        // Spot-check the literal words the fetch should produce.
        step(1, 1, 0, 32'h0, 32'h0, "restart");
        check("lit0", instruction, 32'h0605_0402);
        step(1, 0, 0, 32'h0, 32'h4, "lit4");
        check("lit4.word", instruction, 32'h1009_0801);
        step(1, 0, 0, 32'h0, 32'h8, "lit8");
        check("lit8.word", instruction, 32'h6956_3213);
        check("lit8.next", PC_next_normal, 32'd12);

        // Priority: start over PCSrc, then reset over start.
        F0.start_address <= 32'h40;
        step(1, 1, 1, 32'h80, 32'h40, "prio_start");
        check("prio_sa", F0.start_address, 32'h40);
        step(0, 1, 1, 32'h80, 32'h0, "prio_rst");
        check("prio_sa_clr", F0.start_address, 32'h0);

        // Reset is synchronous: a drop between edges leaves PC alone until the edge.
        step(1, 0, 1, 32'h200, 32'h200, "pre_rst");
        rst = 1'b0;
        #2;
        check("rst_between.next", PC_next_normal, 32'h204);
        exp_q.push_back({32'h0, 32'h4, model_instr(32'h0)});
        @(posedge clk);
        @(negedge clk);
        compare_out("rst_edge");

        // Reset mid-sequence at PC=8.
        step(1, 1, 0, 32'h0, 32'h0, "mid0");
        step(1, 0, 0, 32'h0, 32'h4, "mid4");
        step(1, 0, 0, 32'h0, 32'h8, "mid8");
        step(0, 0, 1, 32'h300, 32'h0, "mid_rst");

        // Random tail with a reference next-PC model.
        m_pc = 32'h0;
        m_sa = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                m_sa = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)} ;
                F0.start_address <= m_sa;
            end
            r  = ($urandom_range(0, 15) != 0);
            s  = ($urandom_range(0, 5) == 0);
            p  = 1'($urandom_range(0, 1));
            br = {16'($urandom_range(0, 32'hFFFF)), 16'($urandom_range(0, 32'hFFFF))};
            if (!r) begin
                m_pc = 32'h0;
                m_sa = 32'h0;
            end else if (s) begin
                m_pc = m_sa;
            end else if (p) begin
                m_pc = br;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            step(r, s, p, br, m_pc, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
